// File: rtl/elevator_scan_ctrl_pkg.sv
// Shared types and constants for the SCAN elevator controller.
package elevator_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMove = 2'b01,
    StDoor = 2'b10
  } state_e;

  localparam logic DirUp = 1'b1;
  localparam logic DirDn = 1'b0;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/elevator_scan_ctrl_door_timer.sv
// Door dwell down-counter: restart loads CYCLES-1, then counts to zero and holds.
module elevator_scan_ctrl_door_timer #(
  parameter int unsigned CYCLES = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  output logic zero
);

  localparam int unsigned TW = $clog2(CYCLES + 1);
  localparam logic [TW-1:0] LoadVal = TW'(CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller: latches cabin/hall calls and serves them in SCAN order
// with a timed door dwell gated by the ready input.
module elevator_scan_ctrl
  import elevator_scan_ctrl_pkg::*;
#(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned DOOR_CYCLES = 8,
  localparam int unsigned FW         = $clog2(FLOORS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [FLOORS-1:0] Ireq,
  input  logic [FLOORS-1:0] Ereq,
  input  logic [FLOORS-1:0] Sens,
  input  logic              R,
  output logic              M,
  output logic              D,
  output logic              P,
  output logic              W,
  output logic              S,
  output logic [FW-1:0]     Floor,
  output logic [FLOORS-1:0] Pend
);

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic              s_q;

  logic [FLOORS-1:0] req, clr, here_mask;
  logic [FW-1:0]     sens_idx;
  logic              sens_valid;
  logic              above, below, ahead, behind;
  logic              req_here, stop, timer_load, mask_here, timer_zero;

  assign req        = Ireq | Ereq;
  assign sens_valid = (popcount16(16'(Sens)) == 5'd1);
  assign req_here   = req[floor_q];

  always_comb begin
    sens_idx = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (Sens[i]) sens_idx = FW'(i);
    end
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend_q[i] && (FW'(i) > floor_q)) above = 1'b1;
      if (pend_q[i] && (FW'(i) < floor_q)) below = 1'b1;
    end
  end

  assign ahead  = (dir_q == DirUp) ? above : below;
  assign behind = (dir_q == DirUp) ? below : above;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    clr        = '0;
    stop       = 1'b0;
    timer_load = 1'b0;
    mask_here  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q[floor_q]) begin
          state_d      = StDoor;
          clr[floor_q] = 1'b1;
          stop         = 1'b1;
          timer_load   = 1'b1;
        end else if (ahead) begin
          state_d = StMove;
        end else if (behind) begin
          state_d = StMove;
          dir_d   = (dir_q == DirUp) ? DirDn : DirUp;
        end
      end
      StMove: begin
        if (sens_valid && pend_q[sens_idx]) begin
          state_d       = StDoor;
          clr[sens_idx] = 1'b1;
          stop          = 1'b1;
          timer_load    = 1'b1;
        end else if (sens_valid &&
                     (((sens_idx == '0) && (dir_q == DirDn)) ||
                      ((sens_idx == FW'(FLOORS - 1)) && (dir_q == DirUp)))) begin
          // Reached the end of the shaft with nothing to serve there.
          state_d = StIdle;
        end
      end
      StDoor: begin
        // A call for this floor re-opens the dwell instead of queueing; beats closing.
        if (req_here) begin
          timer_load = 1'b1;
          mask_here  = 1'b1;
        end else if (timer_zero && R) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    here_mask          = '0;
    here_mask[floor_q] = mask_here;
    pend_d             = (pend_q | req) & ~clr & ~here_mask;
    floor_d            = sens_valid ? sens_idx : floor_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      dir_q   <= DirUp;
      floor_q <= '0;
      pend_q  <= '0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      s_q     <= stop;
    end
  end

  elevator_scan_ctrl_door_timer #(
    .CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .restart (timer_load),
    .zero    (timer_zero)
  );

  assign M     = (state_q == StMove);
  assign P     = (state_q == StDoor);
  assign W     = P && !timer_zero;
  assign D     = dir_q;
  assign S     = s_q;
  assign Floor = floor_q;
  assign Pend  = pend_q;

endmodule
